// File: rtl/rv32m_ext_unit.sv
// rv32m_ext_unit
//
// Multi-cycle RV32M multiply/divide unit placed behind the execute stage's
// external-M port. A request is taken in IDLE and the unit then spends one
// cycle in MUL, 32 cycles in DIV or one cycle in FIX (divide-by-zero and
// signed overflow). It then spends one cycle in ACK, where o_ack pulses and
// o_res holds the result.
//
// Ports
//   i_clk   rising-edge clock
//   i_rst   asynchronous, active-low reset
//   i_en    request; held high with stable operands until o_ack is seen
//   i_rs1   operand A (multiplicand / dividend)
//   i_rs2   operand B (multiplier / divisor)
//   i_f3    funct3 selecting MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   o_res   registered result; holds until the next completion
//   o_ack   registered one-cycle completion pulse
module rv32m_ext_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [2:0]      i_f3,
    output logic [XLEN-1:0] o_res,
    output logic            o_ack
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_ACK
    } state_t;

    state_t state_reg, state_next;

    // Latched request. Only f3[1:0] is needed after dispatch, because the
    // state itself already encodes multiply versus divide.
    logic [XLEN-1:0]   a_reg, b_reg;
    logic [1:0]        op_reg;
    logic              a_sgn_reg, b_sgn_reg;
    logic              neg_q_reg, neg_r_reg;

    // Division datapath: the dividend shifts out of quo_reg while the
    // quotient bits shift in.
    logic [XLEN-1:0]   quo_reg, rem_reg, dvs_reg;
    logic [5:0]        cnt_reg;

    logic [XLEN-1:0]   res_reg;
    logic              ack_reg;

    // ------------------------------------------------------------------
    // Request decode (used only in IDLE)
    // ------------------------------------------------------------------
    logic            a_signed_in, b_signed_in;
    logic            rs1_neg_in, rs2_neg_in;
    logic [XLEN-1:0] rs1_mag_in, rs2_mag_in;
    logic            ovf_in;

    always_comb begin
        a_signed_in = (i_f3 == 3'b001) || (i_f3 == 3'b010) ||
                      (i_f3 == 3'b100) || (i_f3 == 3'b110);
        b_signed_in = (i_f3 == 3'b001) || (i_f3 == 3'b100) ||
                      (i_f3 == 3'b110);
        rs1_neg_in  = a_signed_in && i_rs1[XLEN-1];
        rs2_neg_in  = b_signed_in && i_rs2[XLEN-1];
        // The magnitude of the most negative value is still correct when it
        // is read as unsigned.
        rs1_mag_in  = rs1_neg_in ? -i_rs1 : i_rs1;
        rs2_mag_in  = rs2_neg_in ? -i_rs2 : i_rs2;
        ovf_in      = ((i_f3 == 3'b100) || (i_f3 == 3'b110)) &&
                      (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (i_rs2 == {XLEN{1'b1}});
    end

    // ------------------------------------------------------------------
    // Multiply: 2*XLEN-bit modular product of the sign/zero-extended
    // operands. This equals the low 2*XLEN bits of the 33x33 signed product.
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] a_ext, b_ext, prod;
    logic [XLEN-1:0]   mul_res;

    always_comb begin
        a_ext   = {{XLEN{a_sgn_reg & a_reg[XLEN-1]}}, a_reg};
        b_ext   = {{XLEN{b_sgn_reg & b_reg[XLEN-1]}}, b_reg};
        prod    = a_ext * b_ext;
        mul_res = (op_reg == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // ------------------------------------------------------------------
    // One restoring-division step
    // ------------------------------------------------------------------
    logic [XLEN:0]   rem_shift, diff;
    logic            q_bit;
    logic [XLEN-1:0] rem_step, quo_step, div_res, fix_res;

    always_comb begin
        rem_shift = {rem_reg, quo_reg[XLEN-1]};
        diff      = rem_shift - {1'b0, dvs_reg};
        q_bit     = ~diff[XLEN];
        rem_step  = q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        quo_step  = {quo_reg[XLEN-2:0], q_bit};
        // op_reg[1] separates REM/REMU from DIV/DIVU
        if (op_reg[1])
            div_res = neg_r_reg ? -rem_step : rem_step;
        else
            div_res = neg_q_reg ? -quo_step : quo_step;

        if (b_reg == '0)
            fix_res = op_reg[1] ? a_reg : {XLEN{1'b1}};
        else
            fix_res = op_reg[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    logic            load_op;
    logic            div_step;
    logic            res_we;
    logic [XLEN-1:0] res_next;

    always_comb begin
        state_next = state_reg;
        load_op    = 1'b0;
        div_step   = 1'b0;
        res_we     = 1'b0;
        res_next   = res_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_en) begin
                    load_op = 1'b1;
                    if (!i_f3[2])
                        state_next = ST_MUL;
                    else if ((i_rs2 == '0) || ovf_in)
                        state_next = ST_FIX;
                    else
                        state_next = ST_DIV;
                end
            end
            ST_MUL: begin
                if (!i_en) begin
                    state_next = ST_IDLE;
                end else begin
                    res_we     = 1'b1;
                    res_next   = mul_res;
                    state_next = ST_ACK;
                end
            end
            ST_DIV: begin
                if (!i_en) begin
                    state_next = ST_IDLE;
                end else begin
                    div_step = 1'b1;
                    if (cnt_reg == 6'd31) begin
                        res_we     = 1'b1;
                        res_next   = div_res;
                        state_next = ST_ACK;
                    end
                end
            end
            ST_FIX: begin
                if (!i_en) begin
                    state_next = ST_IDLE;
                end else begin
                    res_we     = 1'b1;
                    res_next   = fix_res;
                    state_next = ST_ACK;
                end
            end
            // The datapath still presents the finished request during ACK,
            // so i_en is deliberately not looked at here.
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            a_sgn_reg <= 1'b0;
            b_sgn_reg <= 1'b0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            quo_reg   <= '0;
            rem_reg   <= '0;
            dvs_reg   <= '0;
            cnt_reg   <= '0;
            res_reg   <= '0;
            ack_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ack_reg   <= (state_next == ST_ACK);
            if (res_we)
                res_reg <= res_next;
            if (load_op) begin
                a_reg     <= i_rs1;
                b_reg     <= i_rs2;
                op_reg    <= i_f3[1:0];
                a_sgn_reg <= a_signed_in;
                b_sgn_reg <= b_signed_in;
                neg_q_reg <= rs1_neg_in ^ rs2_neg_in;
                neg_r_reg <= rs1_neg_in;
                quo_reg   <= rs1_mag_in;
                rem_reg   <= '0;
                dvs_reg   <= rs2_mag_in;
                cnt_reg   <= '0;
            end else if (div_step) begin
                quo_reg <= quo_step;
                rem_reg <= rem_step;
                cnt_reg <= cnt_reg + 6'd1;
            end
        end
    end

    assign o_res = res_reg;
    assign o_ack = ack_reg;

endmodule

// File: tb/tb_rv32m_ext_unit.sv
module tb_rv32m_ext_unit;

    logic        i_clk;
    logic        i_rst;
    logic        i_en;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic [2:0]  i_f3;
    logic [31:0] o_res;
    logic        o_ack;

    rv32m_ext_unit #(.XLEN(32)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (i_en),
        .i_rs1 (i_rs1),
        .i_rs2 (i_rs2),
        .i_f3  (i_f3),
        .o_res (o_res),
        .o_ack (o_ack)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks_cnt = 0;
    int   fail_cnt   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model of the RV32M result
    function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int          sa, sb_;
        logic        ovf;
        sa  = int'(a);
        sb_ = int'(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'b000: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'b010: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'(sa / sb_);
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(sa % sb_);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 2;
        if (b == 0) return 2;
        if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 33;
    endfunction

    // Issue one request from IDLE, wait for its ack and score it
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f3, input logic [31:0] exp_res, input int exp_lat);
        exp_t e;
        int   n;
        bit   got;
        e.res = exp_res;
        e.lat = exp_lat;
        sb.push_back(e);
        i_rs1 = a;
        i_rs2 = b;
        i_f3  = f3;
        i_en  = 1'b1;
        n     = 0;
        got   = 1'b0;
        while (!got && n < 40) begin
            @(posedge i_clk);
            #1;
            n++;
            if (o_ack) got = 1'b1;
        end
        check_eq({tag, "_ack_seen"}, 32'(got), 32'd1);
        e = sb.pop_front();
        if (got) begin
            check_eq({tag, "_res"}, o_res, e.res);
            check_eq({tag, "_lat"}, 32'(n), 32'(e.lat));
        end
        $display("op %s f3=%0d a=%h b=%h res=%h lat=%0d", tag, f3, a, b, o_res, n);
        i_en = 1'b0;
        @(posedge i_clk);
        #1;
        check_eq({tag, "_ack_width"}, 32'(o_ack), 32'd0);
    endtask

    initial begin
        int          n, acks;
        exp_t        e;
        logic [31:0] a, b;
        logic [2:0]  f3;

        i_rst = 1'b0;
        i_en  = 1'b0;
        i_rs1 = '0;
        i_rs2 = '0;
        i_f3  = '0;
        repeat (2) @(posedge i_clk);
        #1;
        check_eq("rst_res", o_res, 32'd0);
        check_eq("rst_ack", 32'(o_ack), 32'd0);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;

        // Directed cases
        run_op("mul_7x-3", 32'd7,          32'hFFFF_FFFD, 3'b000, 32'hFFFF_FFEB, 2);
        run_op("mulh",     32'h8000_0000, 32'hFFFF_FFFF, 3'b001, 32'h0000_0000, 2);
        run_op("mulhu",    32'h8000_0000, 32'hFFFF_FFFF, 3'b011, 32'h7FFF_FFFF, 2);
        run_op("mulhsu",   32'h8000_0000, 32'hFFFF_FFFF, 3'b010, 32'h8000_0000, 2);
        run_op("div",      32'hFFFF_FFEC, 32'd6,         3'b100, 32'hFFFF_FFFD, 33);
        run_op("rem",      32'hFFFF_FFEC, 32'd6,         3'b110, 32'hFFFF_FFFE, 33);
        run_op("divu",     32'hFFFF_FFEC, 32'd6,         3'b101, 32'h2AAA_AAA7, 33);
        run_op("div_by0",  32'd1234,      32'd0,         3'b100, 32'hFFFF_FFFF, 2);
        run_op("remu_by0", 32'd5,         32'd0,         3'b111, 32'd5,         2);
        run_op("div_ovf",  32'h8000_0000, 32'hFFFF_FFFF, 3'b100, 32'h8000_0000, 2);
        run_op("rem_ovf",  32'h8000_0000, 32'hFFFF_FFFF, 3'b110, 32'h0,         2);

        // Random cases against the model, biased toward the special operands
        for (int i = 0; i < 24; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), a, b, f3, model_res(f3, a, b), model_lat(f3, a, b));
        end

        // Back-to-back: DIVU 100/7 then MUL 3x4 with i_en held high
        e.res = 32'd14; e.lat = 33; sb.push_back(e);
        e.res = 32'd12; e.lat = 36; sb.push_back(e);
        i_rs1 = 32'd100; i_rs2 = 32'd7; i_f3 = 3'b101; i_en = 1'b1;
        acks = 0;
        n    = 0;
        while (acks < 2 && n < 45) begin
            @(posedge i_clk);
            #1;
            n++;
            if (o_ack) begin
                acks++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq($sformatf("b2b%0d_res", acks), o_res, e.res);
                    check_eq($sformatf("b2b%0d_lat", acks), 32'(n), 32'(e.lat));
                end
                $display("op b2b%0d res=%h at=%0d", acks, o_res, n);
                if (acks == 1) begin
                    i_rs1 = 32'd3; i_rs2 = 32'd4; i_f3 = 3'b000;
                end
            end
        end
        check_eq("b2b_acks", 32'(acks), 32'd2);
        sb.delete();
        i_en = 1'b0;
        @(posedge i_clk);
        #1;

        // Abort: drop i_en ten cycles into a division
        i_rs1 = 32'd1000; i_rs2 = 32'd3; i_f3 = 3'b100; i_en = 1'b1;
        repeat (10) @(posedge i_clk);
        #1;
        i_en = 1'b0;
        acks = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge i_clk);
            #1;
            if (o_ack) acks++;
        end
        check_eq("abort_no_ack", 32'(acks), 32'd0);
        check_eq("abort_res_held", o_res, 32'd12);
        $display("op abort res=%h acks=%0d", o_res, acks);

        // Asynchronous reset in the middle of a division
        i_rs1 = 32'hFFFF_FFFF; i_rs2 = 32'd3; i_f3 = 3'b101; i_en = 1'b1;
        repeat (8) @(posedge i_clk);
        #2;
        i_rst = 1'b0;
        #1;
        check_eq("arst_res", o_res, 32'd0);
        check_eq("arst_ack", 32'(o_ack), 32'd0);
        i_en = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        check_eq("arst_res_hold", o_res, 32'd0);
        $display("op async_reset res=%h ack=%0d", o_res, o_ack);
        @(posedge i_clk);
        #1;
        run_op("post_rst_div", 32'hFFFF_FFEC, 32'd6, 3'b100, 32'hFFFF_FFFD, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
